prog_loader: RTL
================

# prog_loader

Byte-stream program loader for the single-cycle MIPS core: the write side of the instruction memory the core fetches from. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them to consecutive word addresses starting at 0, and holds the core in reset until the image is complete. It sits between a host link (UART or JTAG bridge) and the instruction memory write port.

## Interface
- ADDR_W, 10, instruction memory word-address width; depth = 2^ADDR_W words (1024).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; arms a new load from IDLE, DONE or ERR.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts a byte; a transfer is `in_valid & in_ready` on a rising edge.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  keeps the core in reset while high.
- done  out  1  image loaded successfully; level signal.
- error  out  1  frame rejected; level signal.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes. The first data byte is word bits [31:24].
- States:
  - IDLE: waiting for `start`.
  - LEN_HI, LEN_LO: capturing N.
  - DATA: receiving words.
  - CSUM: present only with the macro.
  - DONE, ERR.
- Transitions:
  - IDLE→LEN_HI on `start`.
  - LEN_HI→LEN_LO on a transfer.
  - LEN_LO→DATA on a transfer when 0 < N ≤ 2^ADDR_W.
  - LEN_LO→ERR on a transfer when N > 2^ADDR_W.
  - LEN_LO with N = 0 goes to DONE, or to CSUM when the macro is defined.
  - DATA→DONE (or CSUM) when the 4th byte of word N-1 transfers.
  - DONE/ERR→LEN_HI on `start`.
- `in_ready` = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE, DONE and ERR.
- Byte lane counter (2 bits) and word counter (ADDR_W+1 bits):
  - Both clear on entry to LEN_HI.
  - The lane counter wraps 3→0 on each completed word.
  - The word counter increments per completed word. `imem_addr` = word counter value before the increment.
- No memory write ever targets an address ≥ N or ≥ 2^ADDR_W.
- `cpu_hold` = 1 in every state except DONE.
- `done` = (state == DONE).
- `error` = (state == ERR).
- `start` in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- `start` and `reset` together: reset wins.
- Reset mid-load:
  - State goes to IDLE and counters clear.
  - Memory words already written are not cleared.
  - `cpu_hold` stays 1.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_hold` 1, `done` 0, `error` 0. State is IDLE.
- Every output is registered.
- `imem_we` pulses for exactly one cycle, in the cycle after the transfer of a word's 4th byte. `imem_addr` and `imem_wdata` are valid in that cycle.
- Sustained throughput is one byte per cycle. Back-to-back words produce `imem_we` every 4th cycle with no stall.
- DONE is entered on the same edge that raises the final `imem_we`. `done` rises and `cpu_hold` falls together in that cycle.
- ERR is entered on the edge after the offending transfer. `in_ready` is 0 from that cycle on.
- `in_ready` drops in the cycle DONE or ERR is entered. No byte is accepted after the final byte of a frame.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - A running 8-bit XOR covers LEN_HI, LEN_LO and all data bytes.
  - One trailing checksum byte is received in CSUM.
  - Match → DONE; mismatch → ERR.
  - Data words are already written on a mismatch, and `cpu_hold` stays 1.
- Undefined:
  - The CSUM state and the XOR register do not exist.
  - The final data byte (or LEN_LO when N = 0) goes directly to DONE.

## Structure
- Package `prog_loader_pkg`: state enumeration, the 16-bit count width constant, and the lane count constant (4).
- Sub-module `byte_packer`:
  - 32-bit left-shift assembler with a 2-bit lane counter.
  - Inputs: byte and byte strobe.
  - Outputs: `word` and a `word_valid` pulse.
- The top level holds the FSM, word counter, checksum and write-port registers.

## Test plan
- Reset then `start`; frame 00 02 | 12 34 56 78 | DE AD BE EF at one byte per cycle → `imem_we` at addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF, 4 cycles apart; then `done` = 1 and `cpu_hold` = 0.
- Same frame with random `in_valid` gaps → identical writes; no extra `imem_we`.
- N = 0x0401 with ADDR_W = 10 → `error` = 1 after LEN_LO, zero writes, `in_ready` = 0, `cpu_hold` = 1.
- Reset asserted after 5 data bytes → all outputs at reset values; `start` plus a fresh 1-word frame → write at addr 0 and `done`.
- With `PROG_LOADER_CHECKSUM_EN`: frame 00 01 | 01 02 03 04 with checksum 0x05 → DONE; same frame with checksum 0x06 → ERR and `cpu_hold` = 1.
- N = 1024 full image → last write at addr 1023; the word counter never drives addr ≥ 1024.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The CSUM state only exists when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  // Width of the big-endian word-count field at the head of a frame.
  localparam int unsigned CountW = 16;

  // Bytes per instruction word.
  localparam int unsigned NumLanes = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
`ifdef PROG_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in bits [31:24].
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] acc_q;
  logic [1:0]  lane_q;

  // Shift accepted bytes in from the right; lane counter wraps 3->0 per completed word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      lane_q <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      lane_q <= '0;
    end else if (data_valid) begin
      acc_q  <= {acc_q[23:0], data};
      lane_q <= lane_q + 2'd1;
    end
  end

  // Word is presented combinationally with its last byte so the top can register it.
  assign word       = {acc_q[23:0], data};
  assign word_valid = data_valid & (lane_q == 2'(NumLanes - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes a framed image into instruction memory from
// word 0 upward and holds the core in reset until the image is complete.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned MaxWords = 1 << ADDR_W;

  state_e            state_q;
  logic [7:0]        len_hi_q;
  logic [CountW-1:0] n_q;
  logic [ADDR_W:0]   word_cnt_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              xfer;
  logic              arm;
  logic              pack_valid;
  logic              word_valid;
  logic              last_word;
  logic              too_big;
  logic [31:0]       word;
  logic [CountW-1:0] n_new;

  assign xfer       = in_valid & in_ready;
  assign arm        = start & (state_q inside {StIdle, StDone, StErr});
  assign pack_valid = xfer & (state_q == StData);
  assign n_new      = {len_hi_q, in_data};
  assign too_big    = 32'(n_new) > MaxWords;
  // n_q is nonzero whenever we are in DATA, so the subtraction cannot wrap there.
  assign last_word  = (CountW'(word_cnt_q) == n_q - CountW'(1));

  byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (arm),
    .data_valid (pack_valid),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Loader FSM with counters and all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q    <= StLenHi;
            word_cnt_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            in_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_hi_q <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= in_data;
`endif
            state_q  <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            n_q <= n_new;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            if (n_new == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q  <= StCsum;
`else
              state_q  <= StDone;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else if (too_big) begin
              state_q  <= StErr;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            if (word_valid) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt_q[ADDR_W-1:0];
              imem_wdata <= word;
              word_cnt_q <= word_cnt_q + 1'b1;
              if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_q  <= StCsum;
`else
                state_q  <= StDone;
                in_ready <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        StCsum: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (csum_q == in_data) begin
              state_q  <= StDone;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state_q <= StErr;
              error   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q  <= StIdle;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
